sd_stream_sequencer: RTL
========================

# sd_stream_sequencer

Sequences block reads from the SD card SPI controller and turns its byte stream into a paced audio sample stream for the PWM stage. It issues 512-byte block reads at consecutive block-aligned addresses and buffers the bytes in an internal FIFO. It pops one byte per sample period, flags underruns and overruns, and stops after a programmed block count or loops. It sits between `sd_controller` and `audio_PWM`, replacing the free-running `rd=1` tie-off.

## Interface
Parameters:
- `FIFO_DEPTH`, 1024: byte FIFO depth; power of two, ≥ 1024 (two blocks).
- `SAMPLE_DIV`, 3125: clock cycles per sample tick (8 kHz at 25 MHz); ≥ 2.

Ports:
- `clk`, in, 1: single clock (the 25 MHz SD clock); everything is synchronous to it.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse; latches `start_block`, `num_blocks` and `loop_en`; ignored unless IDLE.
- `stop`, in, 1: one-cycle pulse; graceful stop (see Operation).
- `start_block`, in, 23: first block index; byte address = index × 512.
- `num_blocks`, in, 23: blocks to play; 0 is treated as 1.
- `loop_en`, in, 1: after the last block, restart at `start_block`.
- `sd_ready`, in, 1: from `sd_controller.ready`.
- `sd_byte_available`, in, 1: from `sd_controller.byte_available`.
- `sd_dout`, in, 8: from `sd_controller.dout`.
- `sd_rd`, out, 1: read request to `sd_controller`.
- `sd_addr`, out, 32: byte address to `sd_controller`; always 512-aligned.
- `sample`, out, 8: unsigned sample to `audio_PWM`.
- `sample_strobe`, out, 1: one-cycle pulse when `sample` updates.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse on a non-loop finish or a completed stop.
- `underrun`, out, 1: sticky; cleared by `start`.
- `overrun`, out, 1: sticky; cleared by `start`.

## Operation
- Reset values: `sd_rd`=0, `sd_addr`=0, `sample`=8'h80, `sample_strobe`=0, `busy`=0, `done`=0, `underrun`=0, `overrun`=0. FIFO is empty, state is IDLE, divider is 0.
- IDLE → WAIT_RDY on `start`. The start also clears the FIFO, flags and divider, and loads `cur_block`=`start_block` and `blocks_left`=max(`num_blocks`,1).
- WAIT_RDY: when `sd_ready`=1, FIFO free space ≥ 512, and no stop is pending, go to ISSUE. If a stop is pending, go to DRAIN.
- ISSUE: `sd_rd`=1 and `sd_addr`=`cur_block`×512. Hold both until `sd_ready` is sampled 0, then deassert `sd_rd` and go to RECEIVE.
- RECEIVE:
  - Push `sd_dout` into the FIFO on each rising edge of `sd_byte_available`, using a registered previous value for edge detection.
  - Byte counter is 10 bits. After the 512th byte, increment `cur_block` (23-bit wrap) and decrement `blocks_left`.
  - If `blocks_left` becomes 0: with `loop_en`, reload `cur_block`/`blocks_left` and go to WAIT_RDY; without `loop_en`, go to DRAIN.
  - Otherwise go to WAIT_RDY.
- DRAIN: no new reads. When the FIFO is empty, pulse `done` and go to IDLE. On a stop-initiated drain, the FIFO is flushed on entry, so `done` follows on the next cycle.
- `stop`:
  - In WAIT_RDY: go to DRAIN and flush.
  - In ISSUE or RECEIVE: set stop-pending. The current block completes, since `sd_controller` cannot abort; its bytes are discarded, then flush → DRAIN.
  - In IDLE or DRAIN: no effect.
- Sample pacing:
  - The divider runs only while `busy`. A tick occurs when the divider hits `SAMPLE_DIV`-1, after which it resets to 0.
  - On a tick with the FIFO non-empty: pop, register the byte to `sample`, and pulse `sample_strobe`.
  - On a tick with the FIFO empty: `sample` holds its value, no strobe, and `underrun` is set. The exception is the period before the first block's first byte arrives, which does not set `underrun`.
- FIFO push while full: the byte is dropped and `overrun` is set. This is unreachable in correct operation.
- Simultaneous push and pop on the same cycle are both honoured, and the count is unchanged.
- Returning to IDLE sets `sample` to 8'h80.

## Timing
- `start` at cycle N gives `busy`=1 at N+1. `sd_rd` rises at the earliest N+2, if `sd_ready` is already 1.
- `sd_rd` falls the cycle after `sd_ready` is first seen low.
- Push latency: the byte is in the FIFO 2 cycles after the `sd_byte_available` rising edge (1 cycle to register, 1 cycle for edge detect plus write).
- Pop: the tick cycle registers `sample`. `sample_strobe` is high in the same cycle that `sample` shows the new value.
- Strobe period is exactly `SAMPLE_DIV` cycles while the FIFO is non-empty.
- `reset_n` low mid-block forces all outputs to reset values immediately; `sd_rd` drops asynchronously.

## Test plan
- Single block, `num_blocks`=1, SD model returns bytes 0..255,0..255 → one `sd_rd` with `sd_addr`=0. The strobed samples are 0..255,0..255 in order, then `done` pulses and `busy`=0.
- `start_block`=5, `num_blocks`=3 → three reads with addresses 0xA00, 0xC00, 0xE00. There are 1536 strobes, and `underrun` stays 0 with a fast SD model.
- `loop_en`=1, `num_blocks`=2, `start_block`=7 → address sequence 0xE00, 0x1000, 0xE00, 0x1000…, and no `done`.
- SD model stalls 2×`SAMPLE_DIV` cycles before block 2 → `underrun`=1, `sample` holds the last byte of block 1, and no strobes until data resumes.
- `stop` at byte 100 of a block → `sd_rd` is not reasserted. Exactly 512 byte edges are consumed, then the FIFO is flushed, `done` pulses, and `sample`=8'h80.
- `reset_n` pulsed low during RECEIVE → all outputs are at reset values within the cycle. A following `start` replays from the latched `start_block` with the flags cleared.

Source files
------------

// File: rtl/sd_stream_sequencer.sv
// sd_stream_sequencer: issues consecutive 512-byte block reads to the SD SPI
// controller, buffers the returned bytes in a byte FIFO and plays them out at
// one byte per sample period as an unsigned audio sample stream.
//
// Controller handshake: a read request (sd_rd) is raised only from WAIT_RDY
// while sd_ready is high, and sd_rd plus a stable sd_addr are held until
// sd_ready is sampled low, which is the controller's acceptance. The bytes
// of that block are then qualified one at a time by rising edges of
// sd_byte_available, each carrying sd_dout. Exactly 512 edges end a block.
module sd_stream_sequencer #(
    parameter int FIFO_DEPTH = 1024,
    parameter int SAMPLE_DIV = 3125
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic [22:0] start_block,
    input  logic [22:0] num_blocks,
    input  logic        loop_en,
    input  logic        sd_ready,
    input  logic        sd_byte_available,
    input  logic [7:0]  sd_dout,
    output logic        sd_rd,
    output logic [31:0] sd_addr,
    output logic [7:0]  sample,
    output logic        sample_strobe,
    output logic        busy,
    output logic        done,
    output logic        underrun,
    output logic        overrun,
    output logic [2:0]  dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [AW:0]   DEPTH       = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   BLOCK_BYTES = (AW + 1)'(512);
    localparam logic [DW-1:0] DIV_LAST    = DW'(SAMPLE_DIV - 1);
    localparam logic [7:0]    MIDSCALE    = 8'h80;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_ISSUE    = 3'd2,
        S_RECEIVE  = 3'd3,
        S_DRAIN    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Playback configuration captured at start, used for loop reloads.
    logic [22:0] r_start_blk;
    logic [22:0] r_num_blk;
    logic        r_loop;

    logic [22:0] r_cur_block;
    logic [22:0] r_blocks_left;
    logic        r_stop_pend;
    logic [31:0] r_addr;

    // Byte-available synchroniser stage and edge detector.
    logic        r_bav_q;
    logic        r_bav_prev;
    logic [7:0]  r_dout_q;
    logic [9:0]  r_byte_cnt;

    // Byte FIFO.
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0] r_count;

    // Sample pacing and outputs.
    logic [DW-1:0] r_div;
    logic [7:0]  r_sample;
    logic        r_strobe;
    logic        r_done;
    logic        r_underrun;
    logic        r_overrun;
    logic        r_primed;

    logic        w_edge;
    logic        w_block_end;
    logic        w_free_ok;
    logic        w_empty;
    logic        w_full;
    logic        w_tick;
    logic        w_push_req;
    logic        w_push;
    logic        w_pop;
    logic        w_flush;
    logic        w_start_go;
    logic        w_to_idle;
    logic        w_enter_issue;
    logic [9:0]  w_byte_cnt_nxt;

    assign busy          = (r_state != S_IDLE);
    assign sd_rd         = (r_state == S_ISSUE);
    assign sd_addr       = r_addr;
    assign sample        = r_sample;
    assign sample_strobe = r_strobe;
    assign done          = r_done;
    assign underrun      = r_underrun;
    assign overrun       = r_overrun;
    assign dbg_state     = r_state;

    // Datapath qualifiers derived from current registered state.
    always_comb begin
        w_edge      = r_bav_q & ~r_bav_prev;
        w_block_end = (r_state == S_RECEIVE) && w_edge && (r_byte_cnt == 10'd511);
        w_free_ok   = ((DEPTH - r_count) >= BLOCK_BYTES);
        w_empty     = (r_count == '0);
        w_full      = (r_count == DEPTH);
        w_tick      = busy && (r_div == DIV_LAST);
        // Bytes of a block being read out after a stop request are thrown away.
        w_push_req  = (r_state == S_RECEIVE) && w_edge && !r_stop_pend;
        w_push      = w_push_req && !w_full;
        w_pop       = w_tick && !w_empty;
    end

    // Next-state logic and one-cycle control strobes of the sequencer FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_flush       = 1'b0;
        w_start_go    = 1'b0;
        w_to_idle     = 1'b0;
        w_enter_issue = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_WAIT_RDY;
                    w_start_go  = 1'b1;
                end
            end
            S_WAIT_RDY: begin
                if (stop || r_stop_pend) begin
                    w_state_nxt = S_DRAIN;
                    w_flush     = 1'b1;
                end else if (sd_ready && w_free_ok) begin
                    w_state_nxt   = S_ISSUE;
                    w_enter_issue = 1'b1;
                end
            end
            S_ISSUE: begin
                if (!sd_ready) begin
                    w_state_nxt = S_RECEIVE;
                end
            end
            S_RECEIVE: begin
                if (w_block_end) begin
                    if (r_stop_pend || stop) begin
                        w_state_nxt = S_DRAIN;
                        w_flush     = 1'b1;
                    end else if ((r_blocks_left == 23'd1) && !r_loop) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_state_nxt = S_WAIT_RDY;
                    end
                end
            end
            S_DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = S_IDLE;
                    w_to_idle   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Byte counter for the block in flight; idle outside RECEIVE.
    always_comb begin
        w_byte_cnt_nxt = r_byte_cnt;
        if (r_state != S_RECEIVE) begin
            w_byte_cnt_nxt = 10'd0;
        end else if (w_edge) begin
            w_byte_cnt_nxt = r_byte_cnt + 10'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Block bookkeeping: configuration latch, block index/count, stop request, address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_blk   <= '0;
            r_num_blk     <= '0;
            r_loop        <= 1'b0;
            r_cur_block   <= '0;
            r_blocks_left <= '0;
            r_stop_pend   <= 1'b0;
            r_addr        <= '0;
            r_byte_cnt    <= '0;
        end else begin
            r_byte_cnt <= w_byte_cnt_nxt;
            if (w_start_go) begin
                r_start_blk   <= start_block;
                r_num_blk     <= (num_blocks == '0) ? 23'd1 : num_blocks;
                r_loop        <= loop_en;
                r_cur_block   <= start_block;
                r_blocks_left <= (num_blocks == '0) ? 23'd1 : num_blocks;
                r_stop_pend   <= 1'b0;
            end else begin
                if (w_to_idle) begin
                    r_stop_pend <= 1'b0;
                end else if (stop && ((r_state == S_ISSUE) || (r_state == S_RECEIVE))) begin
                    r_stop_pend <= 1'b1;
                end
                if (w_block_end && !r_stop_pend && !stop) begin
                    if ((r_blocks_left == 23'd1) && r_loop) begin
                        r_cur_block   <= r_start_blk;
                        r_blocks_left <= r_num_blk;
                    end else begin
                        r_cur_block   <= r_cur_block + 23'd1;
                        r_blocks_left <= r_blocks_left - 23'd1;
                    end
                end
            end
            if (w_enter_issue) begin
                r_addr <= {r_cur_block, 9'd0};
            end
        end
    end

    // Register the controller byte stream so edge detection sees clean levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bav_q    <= 1'b0;
            r_bav_prev <= 1'b0;
            r_dout_q   <= '0;
        end else begin
            r_bav_q    <= sd_byte_available;
            r_bav_prev <= r_bav_q;
            r_dout_q   <= sd_dout;
        end
    end

    // FIFO storage write port; contents need no reset since the count guards reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_dout_q;
        end
    end

    // FIFO pointers and occupancy; a flush or a new start empties it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush || w_start_go) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sample-period divider, free running only while a playback is active.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (w_start_go || !busy || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Sample output, strobe, completion pulse and sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sample   <= MIDSCALE;
            r_strobe   <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
            r_primed   <= 1'b0;
        end else begin
            r_strobe <= w_pop;
            r_done   <= w_to_idle;
            if (w_to_idle) begin
                r_sample <= MIDSCALE;
            end else if (w_pop) begin
                r_sample <= r_mem[r_rd_ptr];
            end
            if (w_start_go) begin
                r_underrun <= 1'b0;
                r_overrun  <= 1'b0;
                r_primed   <= 1'b0;
            end else begin
                // Empty ticks before the first byte of a playback are expected start-up latency.
                if (w_tick && w_empty && r_primed && (r_state != S_DRAIN)) begin
                    r_underrun <= 1'b1;
                end
                if (w_push_req && w_full) begin
                    r_overrun <= 1'b1;
                end
                if (w_push) begin
                    r_primed <= 1'b1;
                end
            end
        end
    end

endmodule
